// File: rtl/debounce_array.sv
// debounce_array: per-channel 2-flop synchronizer, counting debounce filter, edge pulses and sticky
// pending flags. Defining DEBOUNCE_HOLD_EN adds the long-press hold_o output and its counters.
module debounce_array #(
    parameter int                  CHANNELS      = 4,
    parameter int                  CLK_FREQ      = 50_000_000,
    parameter int                  DEBOUNCE_US   = 1000,
    parameter logic [CHANNELS-1:0] DEBOUNCE_INIT = '0,
    parameter int                  HOLD_US       = 1_000_000
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [CHANNELS-1:0] din_i,
    input  logic [CHANNELS-1:0] clr_i,
    output logic [CHANNELS-1:0] deb_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
`ifdef DEBOUNCE_HOLD_EN
    output logic [CHANNELS-1:0] pend_o,
    output logic [CHANNELS-1:0] hold_o
`else
    output logic [CHANNELS-1:0] pend_o
`endif
);

    localparam int              DEBOUNCE_CYCLES = (CLK_FREQ / 1_000_000) * DEBOUNCE_US;
    localparam int              CW              = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST        = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] r_deb;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_pend;
    logic [CW-1:0]       r_cnt [CHANNELS];

    logic [CHANNELS-1:0] w_diff;
    logic [CHANNELS-1:0] w_toggle;
    logic [CHANNELS-1:0] w_pend_nxt;
    logic [CW-1:0]       w_cnt_nxt [CHANNELS];

    // Two-flop synchronizer on every raw input
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sync1 <= DEBOUNCE_INIT;
            r_sync2 <= DEBOUNCE_INIT;
        end else begin
            r_sync1 <= din_i;
            r_sync2 <= r_sync1;
        end
    end

    // Filter decision: count while the synchronized level disagrees, toggle on the last count
    always_comb begin
        w_diff    = r_sync2 ^ r_deb;
        w_toggle  = '0;
        w_cnt_nxt = '{default: '0};
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_diff[c] && (r_cnt[c] == CNT_LAST)) begin
                w_toggle[c]  = 1'b1;
                w_cnt_nxt[c] = '0;
            end else if (w_diff[c]) begin
                w_cnt_nxt[c] = r_cnt[c] + 1'b1;
            end else begin
                w_cnt_nxt[c] = '0;
            end
        end
        // a new toggle wins over a simultaneous clear
        w_pend_nxt = (r_pend & ~clr_i) | w_toggle;
    end

    // Debounced level, edge pulses, pending flags and filter counters
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_deb  <= DEBOUNCE_INIT;
            r_rise <= '0;
            r_fall <= '0;
            r_pend <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            r_deb  <= r_deb ^ w_toggle;
            r_rise <= w_toggle & ~r_deb;
            r_fall <= w_toggle & r_deb;
            r_pend <= w_pend_nxt;
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= w_cnt_nxt[c];
            end
        end
    end

    assign deb_o  = r_deb;
    assign rise_o = r_rise;
    assign fall_o = r_fall;
    assign pend_o = r_pend;

`ifdef DEBOUNCE_HOLD_EN
    localparam int            HOLD_CYCLES = (CLK_FREQ / 1_000_000) * HOLD_US;
    localparam int            HW          = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES);

    logic [HW-1:0]       r_hcnt [CHANNELS];
    logic [HW-1:0]       w_hcnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] r_hold;
    logic [CHANNELS-1:0] w_hold_nxt;

    // Long-press tracking: saturating count of consecutive cycles with deb high
    always_comb begin
        w_hcnt_nxt = '{default: '0};
        w_hold_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_deb[c] && !w_toggle[c]) begin
                if (r_hcnt[c] == HOLD_LAST) begin
                    w_hcnt_nxt[c] = r_hcnt[c];
                end else begin
                    w_hcnt_nxt[c] = r_hcnt[c] + 1'b1;
                end
            end else begin
                w_hcnt_nxt[c] = '0;
            end
            w_hold_nxt[c] = (w_hcnt_nxt[c] == HOLD_LAST);
        end
    end

    // Hold counters and hold level register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_hold <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_hcnt[c] <= '0;
            end
        end else begin
            r_hold <= w_hold_nxt;
            for (int c = 0; c < CHANNELS; c++) begin
                r_hcnt[c] <= w_hcnt_nxt[c];
            end
        end
    end

    assign hold_o = r_hold;
`endif

endmodule

// File: tb/tb_debounce_array.sv
// Self-checking bench for debounce_array: a sample-window model checked every cycle plus
// directed scenarios with hand-computed edge timing.
module tb_debounce_array;

    localparam int         CH   = 4;
    localparam int         N    = 100;
    localparam int         H    = 500;
    localparam logic [3:0] INIT = 4'b0101;

    logic       clk_i  = 1'b0;
    logic       arst_i = 1'b1;
    logic [3:0] din_i  = INIT;
    logic [3:0] clr_i  = 4'b0000;
    logic [3:0] deb_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic [3:0] pend_o;
`ifdef DEBOUNCE_HOLD_EN
    logic [3:0] hold_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    debounce_array #(
        .CHANNELS      (CH),
        .CLK_FREQ      (50_000_000),
        .DEBOUNCE_US   (2),
        .DEBOUNCE_INIT (INIT),
        .HOLD_US       (10)
    ) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .din_i  (din_i),
        .clr_i  (clr_i),
        .deb_o  (deb_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
`ifdef DEBOUNCE_HOLD_EN
        .pend_o (pend_o),
        .hold_o (hold_o)
`else
        .pend_o (pend_o)
`endif
    );

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: deb flips at edge n when the N samples taken at edges n-N-1 .. n-2 all differ from it.
    logic [3:0] m_deb  = INIT;
    logic [3:0] m_rise = 4'b0000;
    logic [3:0] m_fall = 4'b0000;
    logic [3:0] m_pend = 4'b0000;
    logic [3:0] m_hold = 4'b0000;
    int         m_run [CH];
    logic [3:0] hist [$];

    initial begin : model_cmp
        logic [3:0] tog;
        logic [3:0] s;
        bit         all_diff;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (arst_i) begin
                m_deb  = INIT;
                m_rise = 4'b0000;
                m_fall = 4'b0000;
                m_pend = 4'b0000;
                m_hold = 4'b0000;
                for (int c = 0; c < CH; c++) m_run[c] = 0;
                hist.delete();
            end else begin
                hist.push_back(din_i);
                while (hist.size() > N + 2) void'(hist.pop_front());
                tog = 4'b0000;
                for (int c = 0; c < CH; c++) begin
                    if (hist.size() == N + 2) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < N; k++) begin
                            s = hist[k];
                            if (s[c] == m_deb[c]) all_diff = 1'b0;
                        end
                        tog[c] = all_diff;
                    end
                end
                m_rise = tog & ~m_deb;
                m_fall = tog & m_deb;
                m_pend = (m_pend & ~clr_i) | tog;
                for (int c = 0; c < CH; c++) begin
                    if (m_deb[c] && !tog[c]) begin
                        if (m_run[c] < H) m_run[c] = m_run[c] + 1;
                    end else begin
                        m_run[c] = 0;
                    end
                    m_hold[c] = (m_run[c] >= H);
                end
                m_deb = m_deb ^ tog;
            end
            chk4("model_deb", deb_o, m_deb);
            chk4("model_rise", rise_o, m_rise);
            chk4("model_fall", fall_o, m_fall);
            chk4("model_pend", pend_o, m_pend);
            chk4("rise_and_fall", rise_o & fall_o, 4'b0000);
`ifdef DEBOUNCE_HOLD_EN
            chk4("model_hold", hold_o, m_hold);
`endif
        end
    end

    initial begin : main
        // reset state
        repeat (5) @(posedge clk_i);
        #1;
        chk4("rst_deb", deb_o, 4'b0101);
        chk4("rst_rise", rise_o, 4'b0000);
        chk4("rst_fall", fall_o, 4'b0000);
        chk4("rst_pend", pend_o, 4'b0000);
        @(negedge clk_i);
        arst_i = 1'b0;
        repeat (200) @(posedge clk_i);
        #1;
        chk4("idle_deb", deb_o, 4'b0101);
        chk4("idle_pend", pend_o, 4'b0000);

        // channel 1 rises: low at edge 101, high at edge 102
        @(negedge clk_i);
        din_i[1] = 1'b1;
        repeat (101) @(posedge clk_i);
        #1;
        chk1("c1_deb_e101", deb_o[1], 1'b0);
        @(posedge clk_i);
        #1;
        chk1("c1_deb_e102", deb_o[1], 1'b1);
        chk1("c1_rise_e102", rise_o[1], 1'b1);
        chk1("c1_pend_e102", pend_o[1], 1'b1);
        @(posedge clk_i);
        #1;
        chk1("c1_rise_e103", rise_o[1], 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        chk1("c1_pend_sticky", pend_o[1], 1'b1);
        @(negedge clk_i);
        clr_i[1] = 1'b1;
        @(posedge clk_i);
        #1;
        chk1("c1_pend_clr", pend_o[1], 1'b0);
        @(negedge clk_i);
        clr_i = 4'b0000;

        // channel 0 glitchy fall: 60 low, 5 high, then stable low
        @(negedge clk_i);
        din_i[0] = 1'b0;
        repeat (60) @(negedge clk_i);
        din_i[0] = 1'b1;
        repeat (5) @(negedge clk_i);
        din_i[0] = 1'b0;
        repeat (101) @(posedge clk_i);
        #1;
        chk1("c0_deb_e101", deb_o[0], 1'b1);
        chk1("c0_fall_e101", fall_o[0], 1'b0);
        @(posedge clk_i);
        #1;
        chk1("c0_deb_e102", deb_o[0], 1'b0);
        chk1("c0_fall_e102", fall_o[0], 1'b1);
        @(posedge clk_i);
        #1;
        chk1("c0_fall_e103", fall_o[0], 1'b0);

        // channels 3:2 together, clear of pend[2] on its set edge
        @(negedge clk_i);
        din_i[3:2] = 2'b10;
        repeat (101) @(posedge clk_i);
        #1;
        chk1("c3_deb_e101", deb_o[3], 1'b0);
        chk1("c2_deb_e101", deb_o[2], 1'b1);
        @(negedge clk_i);
        clr_i[2] = 1'b1;
        @(posedge clk_i);
        #1;
        chk1("c3_deb_e102", deb_o[3], 1'b1);
        chk1("c2_deb_e102", deb_o[2], 1'b0);
        chk1("c3_rise_e102", rise_o[3], 1'b1);
        chk1("c2_fall_e102", fall_o[2], 1'b1);
        chk1("c2_pend_set_wins", pend_o[2], 1'b1);
        @(negedge clk_i);
        clr_i = 4'b0000;
        @(posedge clk_i);
        #1;
        chk1("c2_pend_held", pend_o[2], 1'b1);
        @(negedge clk_i);
        clr_i[2] = 1'b1;
        @(posedge clk_i);
        #1;
        chk1("c2_pend_clr", pend_o[2], 1'b0);
        @(negedge clk_i);
        clr_i = 4'b0000;

        // reset in the middle of a filter, then full latency after release
        @(negedge clk_i);
        din_i[2] = 1'b1;
        repeat (50) @(negedge clk_i);
        arst_i = 1'b1;
        #1;
        chk4("arst_deb", deb_o, 4'b0101);
        chk4("arst_rise", rise_o, 4'b0000);
        chk4("arst_fall", fall_o, 4'b0000);
        chk4("arst_pend", pend_o, 4'b0000);
        repeat (3) @(negedge clk_i);
        arst_i = 1'b0;
        repeat (101) @(posedge clk_i);
        #1;
        chk4("rel_deb_e101", deb_o, 4'b0101);
        chk4("rel_rise_e101", rise_o, 4'b0000);
        @(posedge clk_i);
        #1;
        chk4("rel_deb_e102", deb_o, 4'b1110);
        chk4("rel_rise_e102", rise_o, 4'b1010);
        chk4("rel_fall_e102", fall_o, 4'b0001);
        chk4("rel_pend_e102", pend_o, 4'b1011);

        // long press on channel 1 (deb high since the edge above)
        repeat (499) @(posedge clk_i);
        #1;
        chk1("c1_deb_long", deb_o[1], 1'b1);
`ifdef DEBOUNCE_HOLD_EN
        chk1("c1_hold_499", hold_o[1], 1'b0);
`endif
        @(posedge clk_i);
        #1;
`ifdef DEBOUNCE_HOLD_EN
        chk4("hold_500", hold_o, 4'b1110);
`endif
        repeat (100) @(posedge clk_i);
        @(negedge clk_i);
        din_i[1] = 1'b0;
        repeat (101) @(posedge clk_i);
        #1;
        chk1("c1_deb_rel_e101", deb_o[1], 1'b1);
`ifdef DEBOUNCE_HOLD_EN
        chk1("c1_hold_e101", hold_o[1], 1'b1);
`endif
        @(posedge clk_i);
        #1;
        chk1("c1_deb_rel_e102", deb_o[1], 1'b0);
        chk1("c1_fall_rel_e102", fall_o[1], 1'b1);
`ifdef DEBOUNCE_HOLD_EN
        chk4("hold_after_fall", hold_o, 4'b1100);
`endif

        repeat (5) @(posedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
